// File: rtl/dispatch_ctrl_pkg.sv
// Shared RISC-V definitions for the dispatch path: opcodes, FSM encoding,
// queue entry layout and the head-instruction resource classifier.
package riscv_defs;

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_REG   = 7'b0110011;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_JWAIT = 1'b1
    } state_t;

    // Which downstream structure, besides the ROB, an instruction occupies.
    typedef enum logic [1:0] {
        CLS_RS  = 2'd0,
        CLS_LSB = 2'd1,
        CLS_ROB = 2'd2
    } res_class_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        pred;
    } entry_t;

    function automatic res_class_t classify(input logic [6:0] op);
        res_class_t cls;
        case (op)
            OP_AUIPC, OP_JAL, OP_BR, OP_IMM, OP_REG: cls = CLS_RS;
            OP_LOAD, OP_STORE:                       cls = CLS_LSB;
            default:                                 cls = CLS_ROB;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/dispatch_ctrl_fifo.sv
// Circular instruction buffer. Flush wins over push/pop; the caller is
// responsible for never pushing when full or popping when empty.
module inst_fifo
    import riscv_defs::*;
#(
    parameter int QLOG = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  entry_t        wdata,
    output entry_t        rdata,
    output logic [QLOG:0] count,
    output logic          full
);

    localparam int DEPTH = 1 << QLOG;

    entry_t          mem [DEPTH];
    logic [QLOG-1:0] head;
    logic [QLOG-1:0] tail;

    assign rdata = mem[head];
    assign full  = (count == (QLOG+1)'(DEPTH));

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + (QLOG+1)'(1);
                2'b01:   count <= count - (QLOG+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents need no reset because count gates validity.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[tail] <= wdata;
    end

endmodule

// File: rtl/dispatch_ctrl.sv
// Dispatch controller: buffers fetched instructions, issues the head when
// its downstream resources are free, sequences JALR redirects, and flushes
// on rollback.
// Handshakes: a push happens on a cycle where if_valid && if_ready; an
// issue happens on a cycle where dec_valid is high (the decoder always
// accepts). Both take effect at the following rising clock edge.
module dispatch_ctrl
    import riscv_defs::*;
#(
    parameter int QLOG = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rdy,
    input  logic          rollback,
    input  logic          if_valid,
    input  logic [31:0]   if_inst,
    input  logic [31:0]   if_pc,
    input  logic          if_pred_jump,
    output logic          if_ready,
    input  logic          rob_full,
    input  logic          rs_full,
    input  logic          lsb_full,
    output logic          dec_valid,
    output logic [31:0]   dec_inst,
    output logic [31:0]   dec_pc,
    output logic          dec_pred_jump,
    input  logic          jalr_need_pause,
    input  logic          jalr_resolve,
    input  logic [31:0]   jalr_target,
    output logic          redirect_valid,
    output logic [31:0]   redirect_pc,
    output logic [QLOG:0] q_count
);

    state_t      state;
    state_t      state_nxt;
    logic        redir_nxt;
    logic [31:0] redir_pc_nxt;
    entry_t      head_e;
    entry_t      push_e;
    logic        q_full;
    logic        res_ok;
    logic        jalr_issue;
    logic        push;
    logic        pop;
    logic        flush;

    assign dec_inst      = head_e.inst;
    assign dec_pc        = head_e.pc;
    assign dec_pred_jump = head_e.pred;
    assign push_e        = '{inst: if_inst, pc: if_pc, pred: if_pred_jump};

    // Resource check for the head instruction's class.
    always_comb begin
        res_ok = 1'b0;
        case (classify(head_e.inst[6:0]))
            CLS_RS:  res_ok = !rob_full && !rs_full;
            CLS_LSB: res_ok = !rob_full && !lsb_full;
            default: res_ok = !rob_full;
        endcase
    end

    assign dec_valid  = rdy && !rollback && (state == ST_RUN) &&
                        (q_count != '0) && res_ok;
    assign jalr_issue = dec_valid && (head_e.inst[6:0] == OP_JALR);
    // Pushes are refused on a JALR issue: everything behind it is wrong-path.
    assign if_ready   = !rst && rdy && !rollback && (state == ST_RUN) &&
                        !q_full && !jalr_issue;
    assign push       = if_valid && if_ready;
    assign pop        = dec_valid && !jalr_issue;
    assign flush      = rollback || jalr_issue;

    inst_fifo #(.QLOG(QLOG)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata (push_e),
        .rdata (head_e),
        .count (q_count),
        .full  (q_full)
    );

    // JALR sequencing and redirect pulse generation; rollback dominates.
    always_comb begin
        state_nxt    = state;
        redir_nxt    = redirect_valid;
        redir_pc_nxt = redirect_pc;
        if (rollback) begin
            state_nxt = ST_RUN;
            redir_nxt = 1'b0;
        end else if (rdy) begin
            redir_nxt = 1'b0;
            case (state)
                ST_RUN: begin
                    if (jalr_issue) begin
                        if (jalr_resolve) begin
                            redir_nxt    = 1'b1;
                            redir_pc_nxt = jalr_target;
                        end else if (jalr_need_pause) begin
                            state_nxt = ST_JWAIT;
                        end
                    end
                end
                ST_JWAIT: begin
                    if (jalr_resolve) begin
                        redir_nxt    = 1'b1;
                        redir_pc_nxt = jalr_target;
                        state_nxt    = ST_RUN;
                    end
                end
                default: state_nxt = ST_RUN;
            endcase
        end
    end

    // FSM state and registered redirect outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_RUN;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            state          <= state_nxt;
            redirect_valid <= redir_nxt;
            redirect_pc    <= redir_pc_nxt;
        end
    end

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Self-checking bench for dispatch_ctrl: directed scenarios plus a random
// run compared against a queue-based reference model.
module tb_dispatch_ctrl;

    logic        clk = 1'b0;
    logic        rst, rdy, rollback, if_valid, if_pred_jump, if_ready;
    logic [31:0] if_inst, if_pc, dec_inst, dec_pc, jalr_target, redirect_pc;
    logic        rob_full, rs_full, lsb_full, dec_valid, dec_pred_jump;
    logic        jalr_need_pause, jalr_resolve, redirect_valid;
    logic [4:0]  q_count;

    localparam logic [31:0] I_ADDI = 32'h0010_0093;
    localparam logic [31:0] I_LW   = 32'h0000_A103;
    localparam logic [31:0] I_JALR = 32'h0000_80E7;

    always #5 clk = ~clk;

    dispatch_ctrl #(.QLOG(4)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
        .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
        .if_pred_jump(if_pred_jump), .if_ready(if_ready),
        .rob_full(rob_full), .rs_full(rs_full), .lsb_full(lsb_full),
        .dec_valid(dec_valid), .dec_inst(dec_inst), .dec_pc(dec_pc),
        .dec_pred_jump(dec_pred_jump), .jalr_need_pause(jalr_need_pause),
        .jalr_resolve(jalr_resolve), .jalr_target(jalr_target),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .q_count(q_count)
    );

    // Reference model: a plain queue of pending instructions plus a flag
    // for "waiting on a JALR target" and the last redirect.
    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        pred;
    } ent_t;

    ent_t        model_q[$];
    bit          m_jwait;
    bit          m_redir;
    logic [31:0] m_redir_pc;
    int          n_checks = 0;
    int          n_fail   = 0;

    function automatic bit m_res_ok(input logic [31:0] inst);
        case (inst[6:0])
            7'b0010111, 7'b1101111, 7'b1100011, 7'b0010011, 7'b0110011:
                return !rob_full && !rs_full;
            7'b0000011, 7'b0100011:
                return !rob_full && !lsb_full;
            default:
                return !rob_full;
        endcase
    endfunction

    function automatic bit m_dec_valid();
        if (!rdy || rollback || m_jwait || model_q.size() == 0) return 1'b0;
        return m_res_ok(model_q[0].inst);
    endfunction

    function automatic bit m_jalr_issue();
        if (!m_dec_valid()) return 1'b0;
        return model_q[0].inst[6:0] == 7'b1100111;
    endfunction

    function automatic bit m_if_ready();
        return rdy && !rollback && !m_jwait && model_q.size() < 16 && !m_jalr_issue();
    endfunction

    function automatic void m_clear();
        model_q.delete();
        m_jwait    = 1'b0;
        m_redir    = 1'b0;
        m_redir_pc = '0;
    endfunction

    // Advance the model by one clock edge using the inputs now applied.
    function automatic void m_update();
        bit dv, ir, ji;
        dv = m_dec_valid();
        ir = m_if_ready();
        ji = m_jalr_issue();
        if (rollback) begin
            model_q.delete();
            m_jwait = 1'b0;
            m_redir = 1'b0;
        end else if (rdy) begin
            m_redir = 1'b0;
            if (ji) begin
                model_q.delete();
                if (jalr_resolve) begin
                    m_redir = 1'b1; m_redir_pc = jalr_target;
                end else if (jalr_need_pause) begin
                    m_jwait = 1'b1;
                end
            end else if (m_jwait) begin
                if (jalr_resolve) begin
                    m_redir = 1'b1; m_redir_pc = jalr_target; m_jwait = 1'b0;
                end
            end else begin
                if (dv) void'(model_q.pop_front());
                if (if_valid && ir) model_q.push_back('{if_inst, if_pc, if_pred_jump});
            end
        end
    endfunction

    // Driver tasks: inputs change just after the falling edge.
    task automatic idle();
        rdy = 1'b1; rollback = 1'b0; if_valid = 1'b0; if_inst = '0; if_pc = '0;
        if_pred_jump = 1'b0; rob_full = 1'b0; rs_full = 1'b0; lsb_full = 1'b0;
        jalr_need_pause = 1'b0; jalr_resolve = 1'b0; jalr_target = '0;
    endtask

    task automatic fetch(input logic [31:0] inst, input logic [31:0] pc);
        if_valid = 1'b1; if_inst = inst; if_pc = pc; if_pred_jump = pc[2];
    endtask

    task automatic cycle();
        m_update();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic restart();
        rst = 1'b1;
        idle();
        @(negedge clk);
        rst = 1'b0;
        m_clear();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        repeat (2) @(negedge clk);
        fetch(I_ADDI, 32'h0);
        #1;
        n_checks++; if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dec_valid got=%0b exp=0", dec_valid); end
        n_checks++; if (if_ready !== 1'b0) begin n_fail++; $display("FAIL reset_if_ready got=%0b exp=0", if_ready); end
        n_checks++; if (q_count !== 5'd0) begin n_fail++; $display("FAIL reset_q_count got=%0d exp=0", q_count); end
        n_checks++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL reset_redirect_valid got=%0b exp=0", redirect_valid); end
        n_checks++; if (redirect_pc !== 32'h0) begin n_fail++; $display("FAIL reset_redirect_pc got=%h exp=0", redirect_pc); end
        @(negedge clk);
        rst = 1'b0;
        idle();
        m_clear();
    endtask

    task automatic test_addi_lw();
        restart();
        fetch(I_ADDI, 32'h0); #1; cycle();
        fetch(I_LW, 32'h4); #1;
        n_checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'h0) begin n_fail++; $display("FAIL addi_issue valid=%0b pc=%h exp 1/0", dec_valid, dec_pc); end
        cycle();
        if_valid = 1'b0; #1;
        n_checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'h4 || dec_inst !== I_LW) begin n_fail++; $display("FAIL lw_issue valid=%0b pc=%h inst=%h exp 1/4/%h", dec_valid, dec_pc, dec_inst, I_LW); end
        cycle(); #1;
        n_checks++; if (q_count !== 5'd0) begin n_fail++; $display("FAIL addi_lw_drain q_count=%0d exp=0", q_count); end
    endtask

    task automatic test_lsb_stall();
        restart();
        lsb_full = 1'b1;
        fetch(I_LW, 32'h20); #1; cycle();
        if_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if (dec_valid !== 1'b0 || q_count !== 5'd1) begin n_fail++; $display("FAIL lsb_stall cyc=%0d valid=%0b count=%0d exp 0/1", i, dec_valid, q_count); end
            cycle();
        end
        lsb_full = 1'b0; #1;
        n_checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'h20) begin n_fail++; $display("FAIL lsb_release valid=%0b pc=%h exp 1/20", dec_valid, dec_pc); end
        cycle();
    endtask

    task automatic test_full_wrap();
        restart();
        rs_full = 1'b1;
        for (int i = 0; i < 16; i++) begin
            fetch(I_ADDI, 32'(i * 4)); #1;
            n_checks++; if (if_ready !== 1'b1) begin n_fail++; $display("FAIL fill_if_ready i=%0d got=%0b exp=1", i, if_ready); end
            cycle();
        end
        fetch(I_ADDI, 32'h100); #1;
        n_checks++; if (q_count !== 5'd16 || if_ready !== 1'b0) begin n_fail++; $display("FAIL full_state count=%0d if_ready=%0b exp 16/0", q_count, if_ready); end
        rs_full = 1'b0;
        for (int i = 0; i < 24; i++) begin
            fetch(I_ADDI, 32'h100 + 32'(i * 4)); #1;
            n_checks++; if (dec_valid !== 1'b1 || dec_pc !== model_q[0].pc || if_ready !== m_if_ready()) begin
                n_fail++; $display("FAIL wrap_drain i=%0d valid=%0b pc=%h ready=%0b exp 1/%h/%0b", i, dec_valid, dec_pc, if_ready, model_q[0].pc, m_if_ready());
            end
            cycle();
        end
    endtask

    task automatic test_jalr_pause();
        restart();
        rob_full = 1'b1;
        fetch(I_JALR, 32'h40); #1; cycle();
        for (int i = 1; i < 4; i++) begin fetch(I_ADDI, 32'h40 + 32'(i * 4)); #1; cycle(); end
        rob_full = 1'b0; if_valid = 1'b0; jalr_need_pause = 1'b1; #1;
        n_checks++; if (dec_valid !== 1'b1 || dec_inst !== I_JALR || if_ready !== 1'b0 || q_count !== 5'd4) begin
            n_fail++; $display("FAIL jalr_issue valid=%0b inst=%h ready=%0b count=%0d exp 1/%h/0/4", dec_valid, dec_inst, if_ready, q_count, I_JALR);
        end
        cycle();
        jalr_need_pause = 1'b0; fetch(I_ADDI, 32'h50); #1;
        n_checks++; if (q_count !== 5'd0 || if_ready !== 1'b0 || dec_valid !== 1'b0) begin n_fail++; $display("FAIL jwait_hold count=%0d ready=%0b valid=%0b exp 0/0/0", q_count, if_ready, dec_valid); end
        cycle(); #1;
        n_checks++; if (q_count !== 5'd0) begin n_fail++; $display("FAIL jwait_ignore_push count=%0d exp=0", q_count); end
        if_valid = 1'b0; jalr_resolve = 1'b1; jalr_target = 32'h1234; #1;
        cycle();
        jalr_resolve = 1'b0; #1;
        n_checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h1234 || if_ready !== 1'b1) begin
            n_fail++; $display("FAIL jwait_resolve rv=%0b pc=%h ready=%0b exp 1/1234/1", redirect_valid, redirect_pc, if_ready);
        end
        cycle(); #1;
        n_checks++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL redirect_pulse_end got=%0b exp=0", redirect_valid); end
    endtask

    task automatic test_jalr_same_cycle();
        restart();
        fetch(I_JALR, 32'h8); #1; cycle();
        if_valid = 1'b0; jalr_resolve = 1'b1; jalr_target = 32'h80; #1;
        cycle();
        jalr_resolve = 1'b0; #1;
        n_checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h80 || if_ready !== 1'b1 || q_count !== 5'd0) begin
            n_fail++; $display("FAIL jalr_same rv=%0b pc=%h ready=%0b count=%0d exp 1/80/1/0", redirect_valid, redirect_pc, if_ready, q_count);
        end
        cycle(); #1;
        n_checks++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL jalr_same_pulse_end got=%0b exp=0", redirect_valid); end
    endtask

    task automatic test_rollback_jwait();
        restart();
        fetch(I_JALR, 32'hC); #1; cycle();
        fetch(I_ADDI, 32'h10); jalr_need_pause = 1'b1; #1; cycle();
        if_valid = 1'b0; jalr_need_pause = 1'b0;
        rollback = 1'b1; jalr_resolve = 1'b1; jalr_target = 32'h999; #1;
        cycle();
        rollback = 1'b0; jalr_resolve = 1'b0; #1;
        n_checks++; if (redirect_valid !== 1'b0 || q_count !== 5'd0 || if_ready !== 1'b1) begin
            n_fail++; $display("FAIL rollback_jwait rv=%0b count=%0d ready=%0b exp 0/0/1", redirect_valid, q_count, if_ready);
        end
    endtask

    task automatic test_async_reset();
        restart();
        fetch(I_JALR, 32'h4); #1; cycle();
        if_valid = 1'b0; jalr_resolve = 1'b1; jalr_target = 32'h55; #1; cycle();
        jalr_resolve = 1'b0;
        rob_full = 1'b1;
        fetch(I_JALR, 32'h55); #1; cycle();
        fetch(I_ADDI, 32'h59); #1; cycle();
        rob_full = 1'b0; if_valid = 1'b0; jalr_need_pause = 1'b1; #1; cycle();
        jalr_need_pause = 1'b0; fetch(I_ADDI, 32'h60);
        #2 rst = 1'b1;
        #1;
        n_checks++; if (if_ready !== 1'b0 || dec_valid !== 1'b0 || q_count !== 5'd0 || redirect_valid !== 1'b0 || redirect_pc !== 32'h0) begin
            n_fail++; $display("FAIL async_reset ready=%0b valid=%0b count=%0d rv=%0b pc=%h exp all 0", if_ready, dec_valid, q_count, redirect_valid, redirect_pc);
        end
        @(negedge clk);
        rst = 1'b0;
        m_clear();
        #1;
        n_checks++; if (if_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_run if_ready=%0b exp=1", if_ready); end
        cycle();
    endtask

    task automatic test_random();
        logic [31:0] pool [7];
        pool = '{I_ADDI, I_LW, 32'h0020_A023, 32'h0000_10B7, I_JALR, 32'h0000_0463, 32'h0000_0073};
        restart();
        for (int cyc = 0; cyc < 600; cyc++) begin
            rdy             = ($urandom_range(0, 7) != 0);
            rollback        = ($urandom_range(0, 29) == 0);
            if_valid        = ($urandom_range(0, 3) != 0);
            if_inst         = pool[$urandom_range(0, 6)];
            if_pc           = $urandom & 32'hFFFF_FFFC;
            if_pred_jump    = $urandom_range(0, 1);
            rob_full        = ($urandom_range(0, 5) == 0);
            rs_full         = ($urandom_range(0, 3) == 0);
            lsb_full        = ($urandom_range(0, 3) == 0);
            jalr_need_pause = $urandom_range(0, 1);
            jalr_resolve    = ($urandom_range(0, 3) == 0);
            jalr_target     = $urandom;
            #1;
            n_checks++; if (dec_valid !== m_dec_valid() || if_ready !== m_if_ready()) begin
                n_fail++; $display("FAIL rand_hs cyc=%0d valid=%0b ready=%0b exp %0b/%0b", cyc, dec_valid, if_ready, m_dec_valid(), m_if_ready());
            end
            n_checks++; if (q_count !== 5'(model_q.size())) begin n_fail++; $display("FAIL rand_count cyc=%0d got=%0d exp=%0d", cyc, q_count, model_q.size()); end
            n_checks++; if (redirect_valid !== m_redir || redirect_pc !== m_redir_pc) begin
                n_fail++; $display("FAIL rand_redirect cyc=%0d rv=%0b pc=%h exp %0b/%h", cyc, redirect_valid, redirect_pc, m_redir, m_redir_pc);
            end
            if (model_q.size() != 0) begin
                n_checks++; if (dec_inst !== model_q[0].inst || dec_pc !== model_q[0].pc || dec_pred_jump !== model_q[0].pred) begin
                    n_fail++; $display("FAIL rand_head cyc=%0d inst=%h pc=%h pred=%0b exp %h/%h/%0b", cyc, dec_inst, dec_pc, dec_pred_jump, model_q[0].inst, model_q[0].pc, model_q[0].pred);
                end
            end
            cycle();
        end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_addi_lw();
        test_lsb_stall();
        test_full_wrap();
        test_jalr_pause();
        test_jalr_same_cycle();
        test_rollback_jwait();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
